// File: rtl/voice_allocator.sv
// Voice allocator: turns MIDI note-on/off events into voice-indexed strobes for voice_controller.
// A linear scan picks the retrigger, free or oldest voice, and issues one command per event.
module voice_allocator #(
    parameter int NUM_VOICES = 256,
    parameter int VIDX_W     = 8,
    parameter int SEQ_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_evt_valid,
    output logic              o_evt_ready,
    input  logic              i_evt_note_on,
    input  logic [6:0]        i_evt_note,
    input  logic [6:0]        i_evt_velocity,
    input  logic [31:0]       i_evt_tuning_code,
    output logic              o_SPI_flag_dds,
    output logic              o_SPI_flag_adsr,
    output logic [VIDX_W-1:0] o_SPI_voice_index,
    output logic [31:0]       o_SPI_tuning_code,
    output logic [6:0]        o_SPI_velocity,
    output logic              o_SPI_note_status,
    output logic              o_steal,
    output logic [8:0]        o_active_count
);
    localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_ISSUE = 2'd2} state_t;
    state_t r_state, w_state_nxt;

    logic              r_tbl_active [NUM_VOICES];
    logic [6:0]        r_tbl_note   [NUM_VOICES];
    logic [SEQ_W-1:0]  r_tbl_stamp  [NUM_VOICES];
    logic [SEQ_W-1:0]  r_seq;
    logic [VIDX_W-1:0] r_idx;
    logic              r_evt_on;
    logic [6:0]        r_evt_note, r_evt_vel;
    logic [31:0]       r_evt_tun;
    logic              r_match_ok, r_free_ok, r_old_ok;
    logic [VIDX_W-1:0] r_match_idx, r_free_idx, r_old_idx, r_tgt;
    logic [SEQ_W-1:0]  r_old_age;
    logic              r_wr_on, r_wr_off, r_inc;
    logic              r_flag_dds, r_flag_adsr, r_status, r_steal;
    logic [VIDX_W-1:0] r_vidx;
    logic [31:0]       r_tun;
    logic [6:0]        r_vel;
    logic [8:0]        r_count;

    logic              w_accept, w_last, w_cur_active;
    logic [AW-1:0]     w_idx;
    logic [SEQ_W-1:0]  w_cur_age;
    logic              w_match_ok, w_free_ok, w_old_ok;
    logic [VIDX_W-1:0] w_match_idx, w_free_idx, w_old_idx, w_tgt;
    logic [SEQ_W-1:0]  w_old_age;
    logic              w_iss_on, w_iss_off, w_inc, w_steal;

    // Ready is held low while reset is asserted so the front end never sees a phantom accept.
    assign o_evt_ready  = (r_state == S_IDLE) && !i_reset;
    assign w_accept     = i_evt_valid && o_evt_ready;
    assign w_idx        = r_idx[AW-1:0];
    assign w_last       = (r_state == S_SCAN) && (r_idx == VIDX_W'(NUM_VOICES - 1));
    assign w_cur_active = r_tbl_active[w_idx];
    assign w_cur_age    = r_seq - r_tbl_stamp[w_idx];

    // Candidate update folding in the voice examined this cycle; strict compares keep the lowest index on ties.
    always_comb begin
        w_match_ok = r_match_ok; w_match_idx = r_match_idx;
        w_free_ok  = r_free_ok;  w_free_idx  = r_free_idx;
        w_old_ok   = r_old_ok;   w_old_idx   = r_old_idx;  w_old_age = r_old_age;
        if (w_cur_active && (r_tbl_note[w_idx] == r_evt_note) && !r_match_ok) begin
            w_match_ok = 1'b1; w_match_idx = r_idx;
        end else begin
            w_match_ok = w_match_ok;
        end
        if (!w_cur_active && !r_free_ok) begin
            w_free_ok = 1'b1; w_free_idx = r_idx;
        end else begin
            w_free_ok = w_free_ok;
        end
        if (w_cur_active && (!r_old_ok || (w_cur_age > r_old_age))) begin
            w_old_ok = 1'b1; w_old_idx = r_idx; w_old_age = w_cur_age;
        end else begin
            w_old_ok = w_old_ok;
        end
    end

    // Target selection: retrigger beats free voice beats stealing the oldest.
    always_comb begin
        w_iss_on = 1'b0; w_iss_off = 1'b0; w_inc = 1'b0; w_steal = 1'b0; w_tgt = w_old_idx;
        if (r_evt_on) begin
            w_iss_on = 1'b1;
            if (w_match_ok) begin
                w_tgt = w_match_idx;
            end else if (w_free_ok) begin
                w_tgt = w_free_idx; w_inc = 1'b1;
            end else begin
                w_tgt = w_old_idx; w_steal = 1'b1;
            end
        end else if (w_match_ok) begin
            w_iss_off = 1'b1; w_tgt = w_match_idx;
        end else begin
            w_iss_off = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SCAN; else w_state_nxt = S_IDLE;
            S_SCAN:  if (w_last) w_state_nxt = S_ISSUE; else w_state_nxt = S_SCAN;
            S_ISSUE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Datapath: event latch, scan candidates, registered command outputs and the voice table.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_tbl_active[i] <= 1'b0;
                r_tbl_note[i]   <= 7'd0;
                r_tbl_stamp[i]  <= '0;
            end
            r_seq <= '0; r_idx <= '0;
            r_evt_on <= 1'b0; r_evt_note <= 7'd0; r_evt_vel <= 7'd0; r_evt_tun <= 32'd0;
            r_match_ok <= 1'b0; r_free_ok <= 1'b0; r_old_ok <= 1'b0;
            r_match_idx <= '0; r_free_idx <= '0; r_old_idx <= '0; r_old_age <= '0; r_tgt <= '0;
            r_wr_on <= 1'b0; r_wr_off <= 1'b0; r_inc <= 1'b0;
            r_flag_dds <= 1'b0; r_flag_adsr <= 1'b0; r_status <= 1'b0; r_steal <= 1'b0;
            r_vidx <= '0; r_tun <= 32'd0; r_vel <= 7'd0; r_count <= 9'd0;
        end else begin
            r_flag_dds <= 1'b0; r_flag_adsr <= 1'b0; r_steal <= 1'b0;
            r_wr_on <= 1'b0; r_wr_off <= 1'b0; r_inc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_evt_on   <= i_evt_note_on && (i_evt_velocity != 7'd0);
                        r_evt_note <= i_evt_note;
                        r_evt_vel  <= i_evt_velocity;
                        r_evt_tun  <= i_evt_tuning_code;
                        r_idx      <= '0;
                        r_match_ok <= 1'b0; r_free_ok <= 1'b0; r_old_ok <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_idx <= r_idx + VIDX_W'(1);
                    r_match_ok <= w_match_ok; r_match_idx <= w_match_idx;
                    r_free_ok  <= w_free_ok;  r_free_idx  <= w_free_idx;
                    r_old_ok   <= w_old_ok;   r_old_idx   <= w_old_idx;  r_old_age <= w_old_age;
                    if (w_last && (w_iss_on || w_iss_off)) begin
                        r_flag_dds  <= w_iss_on;
                        r_flag_adsr <= 1'b1;
                        r_status    <= w_iss_on;
                        r_steal     <= w_steal;
                        r_vidx      <= w_tgt;
                        r_tun       <= r_evt_tun;
                        r_vel       <= r_evt_vel;
                        r_wr_on     <= w_iss_on;
                        r_wr_off    <= w_iss_off;
                        r_inc       <= w_inc;
                        r_tgt       <= w_tgt;
                    end
                end
                S_ISSUE: begin
                    if (r_wr_on) begin
                        r_tbl_active[r_tgt[AW-1:0]] <= 1'b1;
                        r_tbl_note[r_tgt[AW-1:0]]   <= r_evt_note;
                        r_tbl_stamp[r_tgt[AW-1:0]]  <= r_seq;
                        r_seq <= r_seq + SEQ_W'(1);
                    end else if (r_wr_off) begin
                        r_tbl_active[r_tgt[AW-1:0]] <= 1'b0;
                    end
                    if (r_inc)         r_count <= r_count + 9'd1;
                    else if (r_wr_off) r_count <= r_count - 9'd1;
                end
                default: r_idx <= '0;
            endcase
        end
    end

    assign o_SPI_flag_dds    = r_flag_dds;
    assign o_SPI_flag_adsr   = r_flag_adsr;
    assign o_SPI_voice_index = r_vidx;
    assign o_SPI_tuning_code = r_tun;
    assign o_SPI_velocity    = r_vel;
    assign o_SPI_note_status = r_status;
    assign o_steal           = r_steal;
    assign o_active_count    = r_count;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: a 4-voice and a 256-voice instance, scoreboard of expected command strobes.
module tb_voice_allocator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v4, v256, ev_on;
    logic [6:0]  ev_note, ev_vel;
    logic [31:0] ev_tun;

    logic        a_rdy, a_dds, a_adsr, a_st, a_steal;
    logic [7:0]  a_vidx;
    logic [31:0] a_tun;
    logic [6:0]  a_vel;
    logic [8:0]  a_cnt;
    logic        b_rdy, b_dds, b_adsr, b_st, b_steal;
    logic [7:0]  b_vidx;
    logic [31:0] b_tun;
    logic [6:0]  b_vel;
    logic [8:0]  b_cnt;

    voice_allocator #(.NUM_VOICES(4), .VIDX_W(8), .SEQ_W(16)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_evt_valid(v4), .o_evt_ready(a_rdy),
        .i_evt_note_on(ev_on), .i_evt_note(ev_note), .i_evt_velocity(ev_vel), .i_evt_tuning_code(ev_tun),
        .o_SPI_flag_dds(a_dds), .o_SPI_flag_adsr(a_adsr), .o_SPI_voice_index(a_vidx),
        .o_SPI_tuning_code(a_tun), .o_SPI_velocity(a_vel), .o_SPI_note_status(a_st),
        .o_steal(a_steal), .o_active_count(a_cnt));

    voice_allocator #(.NUM_VOICES(256), .VIDX_W(8), .SEQ_W(16)) u_dut256 (
        .i_clk(clk), .i_reset(rst), .i_evt_valid(v256), .o_evt_ready(b_rdy),
        .i_evt_note_on(ev_on), .i_evt_note(ev_note), .i_evt_velocity(ev_vel), .i_evt_tuning_code(ev_tun),
        .o_SPI_flag_dds(b_dds), .o_SPI_flag_adsr(b_adsr), .o_SPI_voice_index(b_vidx),
        .o_SPI_tuning_code(b_tun), .o_SPI_velocity(b_vel), .o_SPI_note_status(b_st),
        .o_steal(b_steal), .o_active_count(b_cnt));

    bit sel;
    logic        m_rdy, m_dds, m_adsr, m_st, m_steal;
    logic [7:0]  m_vidx;
    logic [31:0] m_tun;
    logic [6:0]  m_vel;
    logic [8:0]  m_cnt;
    assign m_rdy   = sel ? b_rdy   : a_rdy;
    assign m_dds   = sel ? b_dds   : a_dds;
    assign m_adsr  = sel ? b_adsr  : a_adsr;
    assign m_st    = sel ? b_st    : a_st;
    assign m_steal = sel ? b_steal : a_steal;
    assign m_vidx  = sel ? b_vidx  : a_vidx;
    assign m_tun   = sel ? b_tun   : a_tun;
    assign m_vel   = sel ? b_vel   : a_vel;
    assign m_cnt   = sel ? b_cnt   : a_cnt;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          due;
        logic [7:0]  v;
        logic        dds;
        logic        steal;
        logic [31:0] tun;
        logic [6:0]  vel;
    } exp_t;
    exp_t sb[$];

    // Drive one event, track expected strobe through the scoreboard, check latency and active count.
    task automatic send(input bit big, input bit on, input logic [6:0] note, input logic [6:0] vel,
                        input logic [31:0] tun, input bit exp_iss, input logic [7:0] exp_v,
                        input bit exp_steal, input logic [8:0] exp_cnt);
        int   nv, k;
        bit   acc, done;
        exp_t e, got;
        nv = big ? 256 : 4;
        sel = big;
        @(negedge clk);
        ev_on = on; ev_note = note; ev_vel = vel; ev_tun = tun;
        if (big) v256 = 1'b1; else v4 = 1'b1;
        acc = 1'b0;
        for (int g = 0; g < 400 && !acc; g++) begin
            if (m_rdy) acc = 1'b1; else @(negedge clk);
        end
        n_checks++;
        if (!acc) begin
            $display("FAIL accept_timeout note=%0d: ready=%0b required 1", note, m_rdy);
            n_fail++; v4 = 1'b0; v256 = 1'b0;
            return;
        end
        k = cyc + 1;
        if (exp_iss) begin
            e.due = k + nv; e.v = exp_v; e.dds = on && (vel != 7'd0);
            e.steal = exp_steal; e.tun = tun; e.vel = vel;
            sb.push_back(e);
        end
        @(negedge clk);
        v4 = 1'b0; v256 = 1'b0;
        done = 1'b0;
        for (int g = 0; g < nv + 10 && !done; g++) begin
            if (m_dds || m_adsr) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_strobe note=%0d: cyc=%0d vidx=%0d dds=%0b adsr=%0b required none",
                             note, cyc, m_vidx, m_dds, m_adsr);
                    n_fail++;
                end else begin
                    got = sb.pop_front();
                    if (cyc !== got.due || m_vidx !== got.v || m_dds !== got.dds || m_adsr !== 1'b1 ||
                        m_st !== got.dds || m_steal !== got.steal ||
                        (got.dds && (m_tun !== got.tun || m_vel !== got.vel))) begin
                        $display("FAIL strobe note=%0d: cyc=%0d vidx=%0d dds=%0b adsr=%0b st=%0b steal=%0b tun=%0d vel=%0d required cyc=%0d vidx=%0d dds=%0b adsr=1 st=%0b steal=%0b tun=%0d vel=%0d",
                                 note, cyc, m_vidx, m_dds, m_adsr, m_st, m_steal, m_tun, m_vel,
                                 got.due, got.v, got.dds, got.dds, got.steal, got.tun, got.vel);
                        n_fail++;
                    end
                end
            end
            if (m_rdy) done = 1'b1; else @(negedge clk);
        end
        n_checks++;
        if (!done || cyc != k + nv + 1) begin
            $display("FAIL ready_return note=%0d: cyc=%0d done=%0b required cyc=%0d", note, cyc, done, k + nv + 1);
            n_fail++;
        end
        n_checks++;
        if (m_cnt !== exp_cnt) begin
            $display("FAIL active_count note=%0d: got %0d required %0d", note, m_cnt, exp_cnt);
            n_fail++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL missing_strobe note=%0d: %0d pending required 0", note, sb.size());
            n_fail++;
        end
        sb.delete();
    endtask

    // Check that both instances show all-zero outputs.
    task automatic check_zero(input string tag);
        n_checks++;
        if ({a_rdy, a_dds, a_adsr, a_st, a_steal, a_vidx, a_tun, a_vel, a_cnt} !== '0) begin
            $display("FAIL %s_dut4: rdy=%0b dds=%0b adsr=%0b st=%0b steal=%0b vidx=%0d tun=%0d vel=%0d cnt=%0d required all 0",
                     tag, a_rdy, a_dds, a_adsr, a_st, a_steal, a_vidx, a_tun, a_vel, a_cnt);
            n_fail++;
        end
        n_checks++;
        if ({b_rdy, b_dds, b_adsr, b_st, b_steal, b_vidx, b_tun, b_vel, b_cnt} !== '0) begin
            $display("FAIL %s_dut256: rdy=%0b dds=%0b adsr=%0b st=%0b steal=%0b vidx=%0d tun=%0d vel=%0d cnt=%0d required all 0",
                     tag, b_rdy, b_dds, b_adsr, b_st, b_steal, b_vidx, b_tun, b_vel, b_cnt);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin
            $display("FAIL ready_after_reset: dut4=%0b dut256=%0b required 1", a_rdy, b_rdy);
            n_fail++;
        end
    endtask

    task automatic test_alloc_and_steal();
        send(1'b0, 1'b1, 7'd60, 7'd100, 32'd20000000, 1'b1, 8'd0, 1'b0, 9'd1);
        send(1'b0, 1'b1, 7'd62, 7'd90,  32'd21000000, 1'b1, 8'd1, 1'b0, 9'd2);
        send(1'b0, 1'b1, 7'd64, 7'd80,  32'd22000000, 1'b1, 8'd2, 1'b0, 9'd3);
        send(1'b0, 1'b1, 7'd65, 7'd70,  32'd23000000, 1'b1, 8'd3, 1'b0, 9'd4);
        send(1'b0, 1'b1, 7'd67, 7'd60,  32'd24000000, 1'b1, 8'd0, 1'b1, 9'd4);
        // voice 1 (note 62) is now the oldest
        send(1'b0, 1'b1, 7'd69, 7'd50,  32'd25000000, 1'b1, 8'd1, 1'b1, 9'd4);
    endtask

    task automatic test_retrigger();
        test_reset();
        send(1'b0, 1'b1, 7'd60, 7'd100, 32'd20000000, 1'b1, 8'd0, 1'b0, 9'd1);
        send(1'b0, 1'b1, 7'd60, 7'd110, 32'd20000001, 1'b1, 8'd0, 1'b0, 9'd1);
        send(1'b0, 1'b0, 7'd60, 7'd0,   32'd20000000, 1'b1, 8'd0, 1'b0, 9'd0);
    endtask

    task automatic test_note_off_edge();
        send(1'b0, 1'b0, 7'd72, 7'd64,  32'd30000000, 1'b0, 8'd0, 1'b0, 9'd0);
        send(1'b0, 1'b1, 7'd60, 7'd0,   32'd20000000, 1'b0, 8'd0, 1'b0, 9'd0);
        send(1'b0, 1'b1, 7'd61, 7'd100, 32'd20500000, 1'b1, 8'd0, 1'b0, 9'd1);
        send(1'b0, 1'b1, 7'd60, 7'd100, 32'd20000000, 1'b1, 8'd1, 1'b0, 9'd2);
        send(1'b0, 1'b1, 7'd60, 7'd0,   32'd20000000, 1'b1, 8'd1, 1'b0, 9'd1);
    endtask

    task automatic test_reset_mid_scan();
        sel = 1'b0;
        @(negedge clk);
        ev_on = 1'b1; ev_note = 7'd62; ev_vel = 7'd100; ev_tun = 32'd21000000;
        v4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check_zero("mid_scan_reset");
        end
        rst = 1'b0;
        send(1'b0, 1'b1, 7'd60, 7'd100, 32'd20000000, 1'b1, 8'd0, 1'b0, 9'd1);
    endtask

    task automatic test_big();
        send(1'b1, 1'b1, 7'd60, 7'd100, 32'd20000000, 1'b1, 8'd0, 1'b0, 9'd1);
        send(1'b1, 1'b1, 7'd64, 7'd90,  32'd22000000, 1'b1, 8'd1, 1'b0, 9'd2);
        send(1'b1, 1'b0, 7'd60, 7'd0,   32'd20000000, 1'b1, 8'd0, 1'b0, 9'd1);
    endtask

    initial begin
        rst = 1'b1; v4 = 1'b0; v256 = 1'b0; sel = 1'b0;
        ev_on = 1'b0; ev_note = 7'd0; ev_vel = 7'd0; ev_tun = 32'd0;
        test_reset();
        test_alloc_and_steal();
        test_retrigger();
        test_note_off_edge();
        test_reset_mid_scan();
        test_big();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
